// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcode constants, fetch-state encoding.
package cpu_pkg;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 5;

    localparam logic [OPC_W-1:0] OP_NOP = 5'b00000;
    localparam logic [OPC_W-1:0] OP_ADD = 5'b00001;
    localparam logic [OPC_W-1:0] OP_SUB = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LD  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ST  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_CMP = 5'b11001;
    localparam logic [OPC_W-1:0] OP_BEQ = 5'b11010;
    localparam logic [OPC_W-1:0] OP_JMP = 5'b11100;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_FETCH = 2'd1,
        FS_ISSUE = 2'd2,
        FS_HALT  = 2'd3
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC adder: pc + 1, plus the signed branch offset when taken.
module pc_next
    import cpu_pkg::*;
#(
    parameter int W = PC_W
) (
    input  logic [W-1:0] pc,
    input  logic         branch_taken,
    input  logic [W-1:0] branch_off,
    output logic [W-1:0] pc_nxt
);

    // Offset is already W bits wide, so its sign extension to W bits is the
    // value itself; the sum wraps naturally modulo 2^W.
    always_comb begin
        pc_nxt = pc + W'(1) + (branch_taken ? branch_off : '0);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/ISSUE/HALT with valid/ready handoff to decode.
// Build option FETCH_HALT_ON_ZERO_EN: a fetched 16'h0000 word halts instead of issuing.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int PM_DEPTH = 32,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [$clog2(PM_DEPTH)-1:0]  pm_addr,
    input  logic [INSTR_W-1:0]           pm_data,
    output logic [INSTR_W-1:0]           instr,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         branch_taken,
    input  logic [$clog2(PM_DEPTH)-1:0]  branch_off,
    output logic [$clog2(PM_DEPTH)-1:0]  pc,
    output logic                         halted,
    output logic [CNT_W-1:0]             retired
);

    localparam int AW = $clog2(PM_DEPTH);

    localparam logic [1:0] ST_IDLE  = FS_IDLE;
    localparam logic [1:0] ST_FETCH = FS_FETCH;
    localparam logic [1:0] ST_ISSUE = FS_ISSUE;
    localparam logic [1:0] ST_HALT  = FS_HALT;

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [AW-1:0]      pc_nxt;
    logic               accept;

    assign accept = (state_q == ST_ISSUE) && valid_q && instr_ready;

    pc_next #(.W(AW)) u_pc_next (
        .pc           (pc_q),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .pc_nxt       (pc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            ST_FETCH: begin
`ifdef FETCH_HALT_ON_ZERO_EN
                if (pm_data == '0) begin
                    state_d = ST_HALT;
                end else
`endif
                begin
                    instr_d = pm_data;
                    valid_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (accept) begin
                    valid_d   = 1'b0;
                    pc_d      = pc_nxt;
                    state_d   = ST_FETCH;
                    // Saturate rather than wrap so a long run never reads as a short one.
                    retired_d = (retired_q == '1) ? retired_q : retired_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    assign pm_addr     = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;

`ifdef FETCH_HALT_ON_ZERO_EN
    assign halted = (state_q == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard of expected issued instructions.
module tb_fetch_sequencer;
    import cpu_pkg::*;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, start, instr_ready, branch_taken;
    logic [4:0]    branch_off, pm_addr, pc;
    logic [15:0]   pm_data, instr;
    logic          instr_valid, halted;
    logic [CW-1:0] retired;

    logic [15:0] mem [32];
    assign pm_data = mem[pm_addr];

    always #5 clk = ~clk;

    fetch_sequencer #(.PM_DEPTH(32), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pm_addr      (pm_addr),
        .pm_data      (pm_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .pc           (pc),
        .halted       (halted),
        .retired      (retired)
    );

    typedef struct packed {
        logic [4:0]  pc;
        logic [15:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_pc = 0;
    int   exp_ret = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_instr"}, 32'(instr), 32'(e.instr));
            chk({tag, "_pc"}, 32'(pc), 32'(e.pc));
        end
        $display("issue %s: pc=%0d instr=%h retired=%0d", tag, pc, instr, retired);
    endtask

    // One FETCH cycle: expectation queued, optional stray start, issued word checked.
    task automatic fetch_check(input string tag, input logic stray_start);
        logic [4:0] a;
        a = 5'(exp_pc);
        exp_q.push_back('{pc: a, instr: mem[a]});
        start = stray_start;
        step();
        start = 1'b0;
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_retired"}, 32'(retired), 32'(exp_ret));
        pop_check(tag);
    endtask

    task automatic accept(input string tag, input logic taken, input logic [4:0] off);
        int d;
        instr_ready  = 1'b1;
        branch_taken = taken;
        branch_off   = off;
        step();
        instr_ready  = 1'b0;
        branch_taken = 1'($urandom);
        branch_off   = 5'($urandom);
        d = taken ? $signed(off) : 0;
        exp_pc  = (((exp_pc + 1 + d) % 32) + 32) % 32;
        exp_ret = (exp_ret < SAT) ? exp_ret + 1 : SAT;
        chk({tag, "_acc_pc"}, 32'(pc), 32'(exp_pc));
        chk({tag, "_acc_retired"}, 32'(retired), 32'(exp_ret));
        chk({tag, "_acc_valid"}, 32'(instr_valid), 32'd0);
        $display("accept %s: taken=%0b off=%b -> pc=%0d retired=%0d", tag, taken, off, pc, retired);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i) * 16'h0101;
        mem[0]  = 16'hB203;
        mem[29] = 16'h0000;

        reset = 1'b1; start = 1'b0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_off = 5'd0;
        step(); step();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_pm_addr", 32'(pm_addr), 32'd0);
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);

        reset = 1'b0;
        step();
        chk("idle_hold_valid", 32'(instr_valid), 32'd0);

        // Start -> FETCH next cycle, valid one cycle later.
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_fetch_valid", 32'(instr_valid), 32'd0);
        chk("start_fetch_pc", 32'(pc), 32'd0);
        exp_pc = 0; exp_ret = 0;
        fetch_check("first", 1'b0);

        // Stall in ISSUE with noisy branch inputs and a stray start.
        for (int i = 0; i < 5; i++) begin
            branch_taken = 1'b1;
            branch_off   = 5'($urandom);
            start        = (i == 2);
            step();
            start = 1'b0;
            chk("stall_instr", 32'(instr), 32'hB203);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_retired", 32'(retired), 32'd0);
            chk("stall_pc", 32'(pc), 32'd0);
        end

        accept("seq1", 1'b0, 5'd7);
        fetch_check("pc1", 1'b0);
        accept("to22", 1'b1, 5'b10100);
        fetch_check("pc22", 1'b1);
        accept("fwd1", 1'b1, 5'b00001);
        fetch_check("pc24", 1'b0);
        accept("back22", 1'b1, 5'b11101);
        fetch_check("pc22b", 1'b0);
        accept("back2", 1'b1, 5'b11110);
        fetch_check("pc21", 1'b0);
        accept("to31", 1'b1, 5'd9);
        fetch_check("pc31", 1'b0);
        accept("wrap", 1'b0, 5'b10101);
        fetch_check("pc0", 1'b0);
        accept("to29", 1'b1, 5'b11100);

`ifdef FETCH_HALT_ON_ZERO_EN
        step();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_pc", 32'(pc), 32'd29);
        chk("halt_pm_addr", 32'(pm_addr), 32'd29);
        step();
        chk("halt_hold_halted", 32'(halted), 32'd1);
        chk("halt_hold_pc", 32'(pc), 32'd29);
        $display("halt: pc=%0d halted=%0b", pc, halted);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_pc", 32'(pc), 32'd0);
        chk("restart_retired", 32'(retired), 32'd0);
        chk("restart_halted", 32'(halted), 32'd0);
        exp_pc = 0; exp_ret = 0;
        fetch_check("restart", 1'b0);
`else
        fetch_check("zero_word", 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            accept("run", 1'b0, 5'($urandom));
            fetch_check("run", 1'b0);
        end
        chk("retired_sat", 32'(retired), 32'(SAT));

        // Asynchronous reset while an instruction is pending.
        #2;
        reset = 1'b1;
        #1;
        chk("async_pc", 32'(pc), 32'd0);
        chk("async_pm_addr", 32'(pm_addr), 32'd0);
        chk("async_instr", 32'(instr), 32'd0);
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_halted", 32'(halted), 32'd0);
        chk("async_retired", 32'(retired), 32'd0);
        step();
        reset = 1'b0;
        step(); step();
        chk("post_rst_idle_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_idle_pc", 32'(pc), 32'd0);

        start = 1'b1;
        step();
        start = 1'b0;
        exp_pc = 0; exp_ret = 0;
        fetch_check("post_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter PM_DEPTH, default 32, meaning the number of program-memory words; PC width is log2(PM_DEPTH), which is 5 at the default.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the retired-instruction counter.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port start  input  1  is a one-cycle pulse that begins execution from IDLE or HALT.
REQ-006 Port pm_addr  output  5  SHALL drive the address input of the program memory.
REQ-007 Port pm_data  input  16  carries the combinational instruction word returned from the program memory.
REQ-008 Port instr  output  16  SHALL carry the registered instruction presented to decode.
REQ-009 Port instr_valid  output  1  SHALL be high while instr holds an unaccepted instruction.
REQ-010 Port instr_ready  input  1  is driven high by decode to accept instr.
REQ-011 Port branch_taken  input  1  is the branch decision from decode; it is qualified by the accept.
REQ-012 Port branch_off  input  5  is a two's-complement branch offset; it is qualified by the accept.
REQ-013 Port pc  output  5  SHALL show the current program counter.
REQ-014 Port halted  output  1  SHALL be high in the HALT state.
REQ-015 Port retired  output  CNT_W  SHALL count accepted instructions.

Function
REQ-016 The FSM SHALL have states IDLE, FETCH, ISSUE and HALT; state SHALL be IDLE after reset.
REQ-017 IDLE: when start=1, the block SHALL set pc<=0, clear retired and go to FETCH; otherwise it SHALL remain in IDLE.
REQ-018 FETCH: pm_addr SHALL equal pc, and the block SHALL capture instr<=pm_data, set instr_valid<=1 and go to ISSUE; the latency from start to instr_valid SHALL be 2 cycles.
REQ-019 ISSUE: while instr_ready=0, instr and instr_valid SHALL be held stable.
REQ-020 ISSUE accept (instr_valid & instr_ready): the block SHALL clear instr_valid, increment retired and go to FETCH.
REQ-021 On accept with branch_taken=1, the block SHALL set pc<=pc+1+sign_extend(branch_off), modulo 32.
REQ-022 On accept with branch_taken=0, the block SHALL set pc<=pc+1, modulo 32 (31 wraps to 0).
REQ-023 branch_taken and branch_off SHALL be ignored outside an accept.
REQ-024 Sustained throughput SHALL be one instruction per 2 cycles.
REQ-025 The retired counter SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 HALT: halted=1, instr_valid=0 and pc SHALL be held; start SHALL re-enter FETCH with pc=0 and retired cleared.
REQ-027 A start pulse arriving in FETCH or ISSUE SHALL be ignored.
REQ-028 pm_addr SHALL equal pc in every state.

Reset
REQ-029 Asserting reset SHALL immediately force state=IDLE, pc=0, pm_addr=0, instr=16'h0000, instr_valid=0, halted=0 and retired=0, including mid-FETCH or mid-ISSUE.
REQ-030 The first edge after reset deassertion SHALL evaluate the IDLE transitions.

Configuration
REQ-031 With macro FETCH_HALT_ON_ZERO_EN defined, a fetched word of 16'h0000 SHALL NOT raise instr_valid; the block SHALL go from FETCH to HALT and leave pc at the address of the zero word.
REQ-032 Without FETCH_HALT_ON_ZERO_EN, a 16'h0000 word SHALL be issued as a normal instruction, HALT SHALL be unreachable and halted SHALL be tied to 0.

Structure
REQ-033 A shared package cpu_pkg SHALL hold PC_W=5, INSTR_W=16, opcode constants (OP_BEQ=5'b11010, OP_CMP=5'b11001, and others) and the fetch-state enum.
REQ-034 The PC next-value adder SHALL be one sub-module, pc_next, which is combinational and takes pc, branch_taken and branch_off.
REQ-035 The program memory SHALL be instantiated outside this block.

Verification
REQ-036 Reset, then start; memory word 0 = 16'hB203 -> instr_valid high 2 cycles after start, instr=16'hB203, pc=0.
REQ-037 Hold instr_ready=0 for 5 cycles in ISSUE -> instr stable and retired unchanged; ready=1 -> pc=1 and retired=1.
REQ-038 pc=22, accept with branch_taken=1, branch_off=5'b00001 -> pc=24; branch_off=5'b11110 -> pc=21.
REQ-039 pc=31 with a nonzero word, no branch -> pc wraps to 0.
REQ-040 FETCH_HALT_ON_ZERO_EN defined and word 29 = 0 -> halted=1, pc=29, no instr_valid; start -> pc=0 and fetch resumes.
REQ-041 Assert reset while instr_valid=1 -> all outputs at reset values in the same cycle, state IDLE.
